// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Combinational-free package; no latency or backpressure of its own.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam int MUL_CYCLES_DEF = 4;
    localparam int DIV_CYCLES_DEF = 32;
    localparam int MD_CNT_W       = 6;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/md_timer.sv
// Mult/div occupancy tracker: loadable down-counter that raises md_done when it hits zero.
// Load/abort act at the next edge; md_busy/md_done are registered-state decodes.
module md_timer
    import pipe_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rset,
    input  logic                load,
    input  logic [MD_CNT_W-1:0] load_val,
    input  logic                abort,
    output logic                md_busy,
    output logic                md_done
);

    md_state_t           state, state_nxt;
    logic [MD_CNT_W-1:0] md_cnt, md_cnt_nxt;

    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            state  <= RUN;
            md_cnt <= '0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
        end
    end

    // Abort beats a new load; a load in the done cycle chains without an idle cycle.
    always_comb begin
        state_nxt  = state;
        md_cnt_nxt = md_cnt;
        if (abort) begin
            state_nxt  = RUN;
            md_cnt_nxt = '0;
        end else if (load) begin
            state_nxt  = MD_BUSY;
            md_cnt_nxt = load_val;
        end else if (state == MD_BUSY) begin
            if (md_cnt == '0) begin
                state_nxt = RUN;
            end else begin
                md_cnt_nxt = md_cnt - 1'b1;
            end
        end
    end

    assign md_busy = (state == MD_BUSY);
    assign md_done = md_busy && (md_cnt == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: mem wait > exception > mult/div > load-use.
// Zero-cycle response to current inputs; all outputs forced low while rset is asserted.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_hilo_rd,
    input  logic        id_md_op,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rw,
    input  logic        ex_md_start,
    input  logic        ex_md_is_div,
    input  logic        mem_req,
    input  logic        mem_ready,
    input  logic        exc_valid,
    output logic        pc_en,
    output logic        en_if_id,
    output logic        en_id_ex,
    output logic        en_ex_mem,
    output logic        en_mem_wb,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        flush_ex_mem,
    output logic        flush_mem_wb,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] stall_cycles
);

    localparam logic [MD_CNT_W-1:0] MUL_LOAD = MD_CNT_W'(MUL_CYCLES - 1);
    localparam logic [MD_CNT_W-1:0] DIV_LOAD = MD_CNT_W'(DIV_CYCLES - 1);

    logic mem_wait;
    logic exc_take;
    logic md_hazard;
    logic lu_hazard;
    logic md_accept;

    assign mem_wait  = mem_req && !mem_ready;
    assign exc_take  = exc_valid && !mem_wait;
    assign md_hazard = md_busy && !md_done && (id_hilo_rd || id_md_op);
    assign lu_hazard = ex_mem_read && (ex_rw != REG_ZERO) &&
                       ((id_uses_rs && (id_rs == ex_rw)) ||
                        (id_uses_rt && (id_rt == ex_rw)));

    // A start in the done cycle is legal: the unit hands off its result that cycle.
    assign md_accept = ex_md_start && (!md_busy || md_done) && !mem_wait && !exc_take;

    md_timer u_md_timer (
        .clk      (clk),
        .rset     (rset),
        .load     (md_accept),
        .load_val (ex_md_is_div ? DIV_LOAD : MUL_LOAD),
        .abort    (exc_take),
        .md_busy  (md_busy),
        .md_done  (md_done)
    );

    always_comb begin
        pc_en        = 1'b1;
        en_if_id     = 1'b1;
        en_id_ex     = 1'b1;
        en_ex_mem    = 1'b1;
        en_mem_wb    = 1'b1;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        flush_mem_wb = 1'b0;
        if (mem_wait) begin
            pc_en     = 1'b0;
            en_if_id  = 1'b0;
            en_id_ex  = 1'b0;
            en_ex_mem = 1'b0;
            en_mem_wb = 1'b0;
        end else if (exc_take) begin
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
            flush_mem_wb = 1'b1;
        end else if (md_hazard || lu_hazard) begin
            pc_en       = 1'b0;
            en_if_id    = 1'b0;
            flush_id_ex = 1'b1;
        end
        // Hold the whole pipeline inert while reset is asserted.
        if (!rset) begin
            pc_en        = 1'b0;
            en_if_id     = 1'b0;
            en_id_ex     = 1'b0;
            en_ex_mem    = 1'b0;
            en_mem_wb    = 1'b0;
            flush_if_id  = 1'b0;
            flush_id_ex  = 1'b0;
            flush_ex_mem = 1'b0;
            flush_mem_wb = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            stall_cycles <= '0;
        end else if (!pc_en && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: the driver pushes hand-computed expected controls per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rset;
    logic [4:0]  id_rs, id_rt, ex_rw;
    logic        id_uses_rs, id_uses_rt, id_hilo_rd, id_md_op;
    logic        ex_mem_read, ex_md_start, ex_md_is_div;
    logic        mem_req, mem_ready, exc_valid;
    logic        pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
    logic        flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
    logic        md_busy, md_done;
    logic [31:0] stall_cycles;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
        .clk          (clk),
        .rset         (rset),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_hilo_rd   (id_hilo_rd),
        .id_md_op     (id_md_op),
        .ex_mem_read  (ex_mem_read),
        .ex_rw        (ex_rw),
        .ex_md_start  (ex_md_start),
        .ex_md_is_div (ex_md_is_div),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .exc_valid    (exc_valid),
        .pc_en        (pc_en),
        .en_if_id     (en_if_id),
        .en_id_ex     (en_id_ex),
        .en_ex_mem    (en_ex_mem),
        .en_mem_wb    (en_mem_wb),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .flush_ex_mem (flush_ex_mem),
        .flush_mem_wb (flush_mem_wb),
        .md_busy      (md_busy),
        .md_done      (md_done),
        .stall_cycles (stall_cycles)
    );

    // Base control patterns: {pc_en, en x4 (if_id..mem_wb), flush x4 (if_id..mem_wb)}
    localparam logic [8:0] B_RUN  = 9'b1_1111_0000;
    localparam logic [8:0] B_HAZ  = 9'b0_0111_0100;
    localparam logic [8:0] B_MEMW = 9'b0_0000_0000;
    localparam logic [8:0] B_EXC  = 9'b1_1111_1111;
    localparam logic [8:0] B_RST  = 9'b0_0000_0000;

    typedef struct packed {
        logic [10:0] ctl;
        logic [31:0] stall;
        logic [15:0] tag;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_stall = '0;

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; ex_rw = '0;
        id_uses_rs = 0; id_uses_rt = 0; id_hilo_rd = 0; id_md_op = 0;
        ex_mem_read = 0; ex_md_start = 0; ex_md_is_div = 0;
        mem_req = 0; mem_ready = 0; exc_valid = 0;
    endtask

    // Queue the expectation for the cycle whose inputs were just driven, then advance.
    task automatic expect_cyc(input logic [8:0] base, input logic busy, input logic done,
                              input int tag);
        exp_t e;
        if (!rset) exp_stall = '0;
        e.ctl   = {base, busy, done};
        e.stall = exp_stall;
        e.tag   = 16'(tag);
        exp_q.push_back(e);
        if (rset && !base[8] && exp_stall != '1) exp_stall = exp_stall + 1;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t        e;
            logic [10:0] act;
            e   = exp_q.pop_front();
            act = {pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
                   flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb, md_busy, md_done};
            n_tests++;
            if (act !== e.ctl) begin
                n_fail++;
                $display("FAIL ctl tag=%0d t=%0t actual=%b required=%b", e.tag, $time, act, e.ctl);
            end
            n_tests++;
            if (stall_cycles !== e.stall) begin
                n_fail++;
                $display("FAIL stall_cycles tag=%0d t=%0t actual=%0d required=%0d",
                         e.tag, $time, stall_cycles, e.stall);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rset = 1'b0;
        @(posedge clk); #1;
        expect_cyc(B_RST, 0, 0, 0);
        expect_cyc(B_RST, 0, 0, 0);
        rset = 1'b1;
        expect_cyc(B_RUN, 0, 0, 1);

        // Load-use on rs, then rs = $zero, then rt match, then rt unused
        ex_mem_read = 1; ex_rw = 5'd8; id_rs = 5'd8; id_uses_rs = 1;
        expect_cyc(B_HAZ, 0, 0, 10);
        clear_inputs();
        expect_cyc(B_RUN, 0, 0, 11);
        ex_mem_read = 1; ex_rw = 5'd0; id_rs = 5'd0; id_uses_rs = 1;
        expect_cyc(B_RUN, 0, 0, 12);
        clear_inputs();
        ex_mem_read = 1; ex_rw = 5'd9; id_rt = 5'd9; id_uses_rt = 1;
        expect_cyc(B_HAZ, 0, 0, 13);
        id_uses_rt = 0;
        expect_cyc(B_RUN, 0, 0, 14);
        // Mem wait outranks load-use
        id_uses_rt = 1; mem_req = 1; mem_ready = 0;
        expect_cyc(B_MEMW, 0, 0, 15);
        clear_inputs();

        // Divide followed by mflo: 31 stall cycles, proceeds on md_done
        ex_md_start = 1; ex_md_is_div = 1;
        expect_cyc(B_RUN, 0, 0, 20);
        clear_inputs();
        id_hilo_rd = 1;
        for (int i = 0; i < 31; i++) expect_cyc(B_HAZ, 1, 0, 21);
        expect_cyc(B_RUN, 1, 1, 22);
        id_hilo_rd = 0;
        expect_cyc(B_RUN, 0, 0, 23);

        // Mem wait holds everything and masks the exception until ready
        mem_req = 1; mem_ready = 0; exc_valid = 1;
        for (int i = 0; i < 3; i++) expect_cyc(B_MEMW, 0, 0, 30);
        mem_ready = 1;
        expect_cyc(B_EXC, 0, 0, 31);
        clear_inputs();
        expect_cyc(B_RUN, 0, 0, 32);

        // Exception aborts a mult with two cycles left; md_done never pulses
        ex_md_start = 1;
        expect_cyc(B_RUN, 0, 0, 40);
        clear_inputs();
        expect_cyc(B_RUN, 1, 0, 41);
        exc_valid = 1;
        expect_cyc(B_EXC, 1, 0, 42);
        clear_inputs();
        for (int i = 0; i < 5; i++) expect_cyc(B_RUN, 0, 0, 43);

        // Back-to-back mults; md op in ID stalls while busy
        ex_md_start = 1;
        expect_cyc(B_RUN, 0, 0, 50);
        clear_inputs();
        id_md_op = 1;
        expect_cyc(B_HAZ, 1, 0, 51);
        id_md_op = 0;
        for (int i = 0; i < 2; i++) expect_cyc(B_RUN, 1, 0, 52);
        ex_md_start = 1;
        expect_cyc(B_RUN, 1, 1, 53);
        clear_inputs();
        for (int i = 0; i < 3; i++) expect_cyc(B_RUN, 1, 0, 54);
        expect_cyc(B_RUN, 1, 1, 55);
        expect_cyc(B_RUN, 0, 0, 56);

        // Exception drops a same-cycle start
        exc_valid = 1; ex_md_start = 1;
        expect_cyc(B_EXC, 0, 0, 70);
        clear_inputs();
        expect_cyc(B_RUN, 0, 0, 71);

        // Async reset in the middle of a divide
        ex_md_start = 1; ex_md_is_div = 1;
        expect_cyc(B_RUN, 0, 0, 60);
        clear_inputs();
        for (int i = 0; i < 5; i++) expect_cyc(B_RUN, 1, 0, 61);
        id_hilo_rd = 1;
        rset = 1'b0;
        expect_cyc(B_RST, 0, 0, 62);
        expect_cyc(B_RST, 0, 0, 62);
        rset = 1'b1;
        expect_cyc(B_RUN, 0, 0, 63);
        clear_inputs();
        expect_cyc(B_RUN, 0, 0, 64);

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
